// File: rtl/kf8237_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kf8237_pkg
// Brief   : Shared types and mode-register field positions for the KF8237 sequencer
// Rev     : 1.0
// ============================================================================
package kf8237_pkg;

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        S4 = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TYPE_VERIFY  = 2'b00,
        TYPE_WRITE   = 2'b01,
        TYPE_READ    = 2'b10,
        TYPE_ILLEGAL = 2'b11
    } transfer_type_t;

    typedef enum logic [1:0] {
        MODE_DEMAND  = 2'b00,
        MODE_SINGLE  = 2'b01,
        MODE_BLOCK   = 2'b10,
        MODE_CASCADE = 2'b11
    } transfer_mode_t;

    // Bit positions inside the 8-bit mode byte; bits [1:0] only address the channel
    localparam int c_type_lsb      = 2;
    localparam int c_autoinit_bit  = 4;
    localparam int c_decrement_bit = 5;
    localparam int c_mode_lsb      = 6;

endpackage
`default_nettype wire

// File: rtl/kf8237_timing_and_control_if.sv
`default_nettype none
// ============================================================================
// Module  : kf8237_timing_and_control_if
// Brief   : System-bus handshake and strobe pins of the KF8237 sequencer
// Rev     : 1.0
// ============================================================================
interface kf8237_timing_and_control_if;

    logic hold_request;
    logic hold_acknowledge;
    logic ready;
    logic end_of_process_in;
    logic end_of_process_out;
    logic address_enable;
    logic address_strobe;
    logic memory_read_n;
    logic memory_write_n;
    logic io_read_n_out;
    logic io_write_n_out;

    modport master (
        input  hold_acknowledge, ready, end_of_process_in,
        output hold_request, end_of_process_out, address_enable, address_strobe,
               memory_read_n, memory_write_n, io_read_n_out, io_write_n_out
    );

    modport slave (
        output hold_acknowledge, ready, end_of_process_in,
        input  hold_request, end_of_process_out, address_enable, address_strobe,
               memory_read_n, memory_write_n, io_read_n_out, io_write_n_out
    );

endinterface
`default_nettype wire

// File: rtl/kf8237_mode_registers.sv
`default_nettype none
// ============================================================================
// Module  : kf8237_mode_registers
// Brief   : Per-channel mode storage with field mux for the active channel
// Rev     : 1.0
// ============================================================================
module kf8237_mode_registers
    import kf8237_pkg::*;
#(
    parameter int CHANNELS = 4
)
(
    input  wire                  clock,
    input  wire                  reset_n,
    input  wire                  master_clear,
    input  wire                  write_mode_register,
    input  wire  [7:0]           internal_data_bus,
    input  wire  [CHANNELS-1:0]  channel_select,
    output transfer_type_t       transfer_type,
    output transfer_mode_t       transfer_mode,
    output logic                 autoinit,
    output logic                 decrement
);

    localparam int c_stored_width = 8 - c_type_lsb;

    logic [CHANNELS-1:0]        w_write_select;
    logic [c_stored_width-1:0]  r_mode [CHANNELS];
    logic [c_stored_width-1:0]  w_active;

    assign w_write_select = write_mode_register
                          ? ({{(CHANNELS-1){1'b0}}, 1'b1} << internal_data_bus[1:0])
                          : '0;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_mode
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_mode[i] <= '0;
                end else if (master_clear) begin
                    r_mode[i] <= '0;
                end else if (w_write_select[i]) begin
                    r_mode[i] <= internal_data_bus[7:c_type_lsb];
                end
            end
        end
    endgenerate

    // One-hot select, so an OR-reduction is a full mux; no channel yields all zeros
    always_comb begin
        w_active = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (channel_select[i]) begin
                w_active = w_active | r_mode[i];
            end
        end
    end

    assign transfer_type = transfer_type_t'(w_active[c_type_lsb-c_type_lsb +: 2]);
    assign transfer_mode = transfer_mode_t'(w_active[c_mode_lsb-c_type_lsb +: 2]);
    assign autoinit      = w_active[c_autoinit_bit-c_type_lsb];
    assign decrement     = w_active[c_decrement_bit-c_type_lsb];

endmodule
`default_nettype wire

// File: rtl/kf8237_timing_and_control.sv
`default_nettype none
// ============================================================================
// Module  : kf8237_timing_and_control
// Brief   : KF8237 transfer sequencer: hold handshake, bus-cycle FSM, TC/EOP
// Rev     : 1.0
// ============================================================================
module kf8237_timing_and_control
    import kf8237_pkg::*;
#(
    parameter int CHANNELS = 4
)
(
    input  wire                          clock,
    input  wire                          reset_n,
    kf8237_timing_and_control_if.master  bus,
    input  wire  [7:0]                   internal_data_bus,
    input  wire                          write_mode_register,
    input  wire                          write_command_register,
    input  wire                          master_clear,
    input  wire  [CHANNELS-1:0]          encoded_dma,
    input  wire                          underflow,
    output logic [CHANNELS-1:0]          dma_acknowledge_internal,
    output logic                         end_of_process_internal,
    output logic [CHANNELS-1:0]          transfer_register_select,
    output logic                         next_word,
    output logic                         initialize_current_register,
    output logic                         decrement_address_config,
    output logic                         lock_bus_control
);

    state_t               r_state;
    state_t               w_next_state;
    logic [CHANNELS-1:0]  r_channel;
    logic [CHANNELS-1:0]  w_next_channel;
    logic                 r_disable;

    transfer_type_t       w_type;
    transfer_mode_t       w_mode;
    logic                 w_autoinit;
    logic                 w_request;
    logic                 w_cascade;
    logic                 w_terminal_count;

    logic                 w_hold_request;
    logic                 w_address_enable;
    logic                 w_address_strobe;
    logic                 w_memory_read_n;
    logic                 w_memory_write_n;
    logic                 w_io_read_n;
    logic                 w_io_write_n;
    logic                 w_end_of_process_n;

    kf8237_mode_registers #(
        .CHANNELS            (CHANNELS)
    ) u_mode_registers (
        .clock               (clock),
        .reset_n             (reset_n),
        .master_clear        (master_clear),
        .write_mode_register (write_mode_register),
        .internal_data_bus   (internal_data_bus),
        .channel_select      (r_channel),
        .transfer_type       (w_type),
        .transfer_mode       (w_mode),
        .autoinit            (w_autoinit),
        .decrement           (decrement_address_config)
    );

    assign w_request        = |encoded_dma;
    assign w_cascade        = (w_mode == MODE_CASCADE);
    assign w_terminal_count = (r_state == S4) && (underflow || !bus.end_of_process_in);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= SI;
            r_channel <= '0;
            r_disable <= 1'b0;
        end else if (master_clear) begin
            r_state   <= SI;
            r_channel <= '0;
            r_disable <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_channel <= w_next_channel;
            if (write_command_register) begin
                r_disable <= internal_data_bus[2];
            end
        end
    end

    always_comb begin
        w_next_state                = r_state;
        w_next_channel              = r_channel;
        w_hold_request              = 1'b0;
        w_address_enable            = 1'b0;
        w_address_strobe            = 1'b0;
        w_memory_read_n             = 1'b1;
        w_memory_write_n            = 1'b1;
        w_io_read_n                 = 1'b1;
        w_io_write_n                = 1'b1;
        w_end_of_process_n          = 1'b1;
        dma_acknowledge_internal    = '0;
        transfer_register_select    = '0;
        end_of_process_internal     = 1'b0;
        next_word                   = 1'b0;
        initialize_current_register = 1'b0;
        lock_bus_control            = 1'b0;

        case (r_state)
            SI: begin
                if (w_request && !r_disable) begin
                    w_next_state = S0;
                end
            end
            S0: begin
                w_hold_request = 1'b1;
                if (bus.hold_acknowledge && w_request) begin
                    w_next_state   = S1;
                    w_next_channel = encoded_dma;
                end else if (!w_request) begin
                    w_next_state = SI;
                end
            end
            S1: begin
                w_hold_request           = 1'b1;
                dma_acknowledge_internal = r_channel;
                lock_bus_control         = 1'b1;
                // A cascaded slave owns the bus: hold DACK only while it keeps requesting
                if (w_cascade) begin
                    if (encoded_dma != r_channel) begin
                        w_next_state = SI;
                    end
                end else begin
                    w_address_enable         = 1'b1;
                    w_address_strobe         = 1'b1;
                    transfer_register_select = r_channel;
                    w_next_state             = S2;
                end
            end
            S2, S3: begin
                w_hold_request           = 1'b1;
                w_address_enable         = 1'b1;
                dma_acknowledge_internal = r_channel;
                transfer_register_select = r_channel;
                lock_bus_control         = 1'b1;
                w_memory_read_n          = (w_type != TYPE_READ);
                w_io_read_n              = (w_type != TYPE_WRITE);
                if (r_state == S3) begin
                    w_io_write_n     = (w_type != TYPE_READ);
                    w_memory_write_n = (w_type != TYPE_WRITE);
                    if (bus.ready) begin
                        w_next_state = S4;
                    end
                end else begin
                    w_next_state = S3;
                end
            end
            S4: begin
                w_hold_request              = 1'b1;
                w_address_enable            = 1'b1;
                dma_acknowledge_internal    = r_channel;
                transfer_register_select    = r_channel;
                lock_bus_control            = 1'b1;
                next_word                   = 1'b1;
                end_of_process_internal     = w_terminal_count;
                w_end_of_process_n          = !w_terminal_count;
                initialize_current_register = w_terminal_count && w_autoinit;
                if (w_terminal_count || r_disable || w_mode == MODE_SINGLE || w_cascade) begin
                    w_next_state = SI;
                end else if (w_mode == MODE_BLOCK || encoded_dma == r_channel) begin
                    w_next_state = S1;
                end else begin
                    w_next_state = SI;
                end
            end
            default: begin
                w_next_state = SI;
            end
        endcase
    end

    assign bus.hold_request       = w_hold_request;
    assign bus.address_enable     = w_address_enable;
    assign bus.address_strobe     = w_address_strobe;
    assign bus.memory_read_n      = w_memory_read_n;
    assign bus.memory_write_n     = w_memory_write_n;
    assign bus.io_read_n_out      = w_io_read_n;
    assign bus.io_write_n_out     = w_io_write_n;
    assign bus.end_of_process_out = w_end_of_process_n;

endmodule
`default_nettype wire

// File: tb/tb_kf8237_timing_and_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_kf8237_timing_and_control
// Brief   : Directed self-checking bench for the KF8237 transfer sequencer
// Rev     : 1.0
// ============================================================================
module tb_kf8237_timing_and_control;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  data;
    logic        wr_mode;
    logic        wr_cmd;
    logic        mclr;
    logic [3:0]  encoded_dma;
    logic        underflow;
    logic [3:0]  dack;
    logic        eop_int;
    logic [3:0]  select;
    logic        next_word;
    logic        init_cur;
    logic        decrement;
    logic        lock;

    // Word-count model of the address/count block
    logic [15:0] cnt;
    logic        cnt_load;
    logic [15:0] cnt_load_val;

    int n_checks = 0;
    int n_fail   = 0;

    kf8237_timing_and_control_if bus ();

    kf8237_timing_and_control #(.CHANNELS(4)) dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .bus                         (bus),
        .internal_data_bus           (data),
        .write_mode_register         (wr_mode),
        .write_command_register      (wr_cmd),
        .master_clear                (mclr),
        .encoded_dma                 (encoded_dma),
        .underflow                   (underflow),
        .dma_acknowledge_internal    (dack),
        .end_of_process_internal     (eop_int),
        .transfer_register_select    (select),
        .next_word                   (next_word),
        .initialize_current_register (init_cur),
        .decrement_address_config    (decrement),
        .lock_bus_control            (lock)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (cnt_load) cnt <= cnt_load_val;
        else if (next_word) cnt <= cnt - 16'd1;
    end
    assign underflow = (cnt == 16'd0);

    wire [3:0] strobes = {bus.memory_read_n, bus.memory_write_n, bus.io_read_n_out, bus.io_write_n_out};
    wire [3:0] ctl     = {bus.hold_request, bus.address_enable, bus.address_strobe, lock};
    wire [1:0] eop     = {bus.end_of_process_out, eop_int};

    task automatic setup(input logic [7:0] mode, input logic [15:0] count);
        data = mode; wr_mode = 1'b1; cnt_load_val = count; cnt_load = 1'b1;
        @(negedge clock);
        wr_mode = 1'b0; cnt_load = 1'b0; data = 8'h00;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        n_checks++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl got %b expected 0000", ctl); end
        n_checks++; if (strobes !== 4'b1111) begin n_fail++; $display("FAIL reset_strobes got %b expected 1111", strobes); end
        n_checks++; if ({dack, select} !== 8'h00) begin n_fail++; $display("FAIL reset_dack_sel got %h expected 00", {dack, select}); end
        n_checks++; if ({eop, next_word, init_cur} !== 4'b1000) begin n_fail++; $display("FAIL reset_eop_pulses got %b expected 1000", {eop, next_word, init_cur}); end
        reset_n = 1'b1; cnt_load = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.hold_request !== 1'b0) begin n_fail++; $display("FAIL idle_hrq got %b expected 0", bus.hold_request); end
    endtask

    task automatic test_disable_and_withdraw;
        data = 8'h04; wr_cmd = 1'b1;
        @(negedge clock);
        wr_cmd = 1'b0; data = 8'h00; encoded_dma = 4'b0001;
        @(negedge clock);
        n_checks++; if (bus.hold_request !== 1'b0) begin n_fail++; $display("FAIL disabled_hrq got %b expected 0", bus.hold_request); end
        wr_cmd = 1'b1;
        @(negedge clock);
        wr_cmd = 1'b0;
        n_checks++; if (bus.hold_request !== 1'b0) begin n_fail++; $display("FAIL reenable_hrq got %b expected 0", bus.hold_request); end
        @(negedge clock);
        n_checks++; if (bus.hold_request !== 1'b1) begin n_fail++; $display("FAIL enabled_hrq got %b expected 1", bus.hold_request); end
        encoded_dma = 4'b0000;
        @(negedge clock);
        n_checks++; if (bus.hold_request !== 1'b0) begin n_fail++; $display("FAIL withdraw_hrq got %b expected 0", bus.hold_request); end
    endtask

    task automatic test_single_read;
        setup(8'h49, 16'd2);
        encoded_dma = 4'b0010;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            n_checks++; if (ctl !== 4'b1000) begin n_fail++; $display("FAIL sr_s0_ctl t=%0d got %b expected 1000", t, ctl); end
            bus.hold_acknowledge = 1'b1;
            @(negedge clock);
            n_checks++; if ({ctl, strobes} !== 8'b1111_1111) begin n_fail++; $display("FAIL sr_s1 t=%0d got %b expected 11111111", t, {ctl, strobes}); end
            n_checks++; if ({dack, select} !== 8'h22) begin n_fail++; $display("FAIL sr_s1_dack_sel t=%0d got %h expected 22", t, {dack, select}); end
            @(negedge clock);
            n_checks++; if ({ctl, strobes} !== 8'b1101_0111) begin n_fail++; $display("FAIL sr_s2 t=%0d got %b expected 11010111", t, {ctl, strobes}); end
            @(negedge clock);
            n_checks++; if ({ctl, strobes} !== 8'b1101_0110) begin n_fail++; $display("FAIL sr_s3 t=%0d got %b expected 11010110", t, {ctl, strobes}); end
            @(negedge clock);
            n_checks++; if ({strobes, next_word} !== 5'b1111_1) begin n_fail++; $display("FAIL sr_s4 t=%0d got %b expected 11111", t, {strobes, next_word}); end
            n_checks++; if (eop !== ((t == 2) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL sr_s4_eop t=%0d got %b expected %b", t, eop, (t == 2) ? 2'b01 : 2'b10); end
            bus.hold_acknowledge = 1'b0;
            if (t == 2) encoded_dma = 4'b0000;
            @(negedge clock);
            n_checks++; if ({ctl, dack, next_word} !== 9'b0) begin n_fail++; $display("FAIL sr_gap t=%0d got %b expected 000000000", t, {ctl, dack, next_word}); end
        end
        n_checks++; if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sr_count got %h expected ffff", cnt); end
    endtask

    task automatic test_block_write;
        setup(8'h84, 16'd3);
        encoded_dma = 4'b0001;
        @(negedge clock);
        bus.hold_acknowledge = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            n_checks++; if ({ctl, dack, decrement} !== 9'b1111_0001_0) begin n_fail++; $display("FAIL bw_s1 t=%0d got %b expected 111100010", t, {ctl, dack, decrement}); end
            @(negedge clock);
            n_checks++; if (strobes !== 4'b1101) begin n_fail++; $display("FAIL bw_s2 t=%0d got %b expected 1101", t, strobes); end
            @(negedge clock);
            n_checks++; if (strobes !== 4'b1001) begin n_fail++; $display("FAIL bw_s3 t=%0d got %b expected 1001", t, strobes); end
            @(negedge clock);
            n_checks++; if ({bus.hold_request, next_word, init_cur} !== 3'b110) begin n_fail++; $display("FAIL bw_s4 t=%0d got %b expected 110", t, {bus.hold_request, next_word, init_cur}); end
            n_checks++; if (eop !== ((t == 3) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL bw_s4_eop t=%0d got %b expected %b", t, eop, (t == 3) ? 2'b01 : 2'b10); end
            if (t == 3) begin encoded_dma = 4'b0000; bus.hold_acknowledge = 1'b0; end
        end
        @(negedge clock);
        n_checks++; if ({ctl, dack} !== 8'h00) begin n_fail++; $display("FAIL bw_end got %b expected 00000000", {ctl, dack}); end
        n_checks++; if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL bw_count got %h expected ffff", cnt); end
    endtask

    task automatic test_demand;
        setup(8'h26, 16'd5);
        encoded_dma = 4'b0100;
        @(negedge clock);
        bus.hold_acknowledge = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clock);
            n_checks++; if ({dack, select, decrement} !== 9'b0100_0100_1) begin n_fail++; $display("FAIL dm_s1 t=%0d got %b expected 010001001", t, {dack, select, decrement}); end
            repeat (2) @(negedge clock);
            n_checks++; if (strobes !== 4'b1001) begin n_fail++; $display("FAIL dm_s3 t=%0d got %b expected 1001", t, strobes); end
            @(negedge clock);
            n_checks++; if ({eop, next_word} !== 3'b101) begin n_fail++; $display("FAIL dm_s4 t=%0d got %b expected 101", t, {eop, next_word}); end
            if (t == 1) begin encoded_dma = 4'b0000; bus.hold_acknowledge = 1'b0; end
        end
        @(negedge clock);
        n_checks++; if ({ctl, dack, eop} !== 10'b0000_0000_10) begin n_fail++; $display("FAIL dm_end got %b expected 0000000010", {ctl, dack, eop}); end
        n_checks++; if (cnt !== 16'd3) begin n_fail++; $display("FAIL dm_count got %h expected 0003", cnt); end
    endtask

    task automatic test_ready_wait;
        setup(8'h4B, 16'd0);
        encoded_dma = 4'b1000;
        @(negedge clock);
        bus.hold_acknowledge = 1'b1;
        repeat (2) @(negedge clock);
        bus.ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            @(negedge clock);
            n_checks++; if ({strobes, next_word} !== 5'b0110_0) begin n_fail++; $display("FAIL rw_s3 w=%0d got %b expected 01100", w, {strobes, next_word}); end
        end
        bus.ready = 1'b1;
        @(negedge clock);
        n_checks++; if ({strobes, next_word, eop} !== 7'b1111_1_01) begin n_fail++; $display("FAIL rw_s4 got %b expected 1111101", {strobes, next_word, eop}); end
        encoded_dma = 4'b0000; bus.hold_acknowledge = 1'b0;
        @(negedge clock);
        n_checks++; if ({next_word, bus.hold_request} !== 2'b00) begin n_fail++; $display("FAIL rw_end got %b expected 00", {next_word, bus.hold_request}); end
        n_checks++; if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL rw_count got %h expected ffff", cnt); end
    endtask

    task automatic test_eop_autoinit;
        setup(8'h58, 16'd5);
        encoded_dma = 4'b0001;
        @(negedge clock);
        bus.hold_acknowledge = 1'b1;
        repeat (3) @(negedge clock);
        bus.end_of_process_in = 1'b0;
        n_checks++; if ({eop, init_cur} !== 3'b100) begin n_fail++; $display("FAIL ea_s3 got %b expected 100", {eop, init_cur}); end
        @(negedge clock);
        n_checks++; if ({eop, init_cur, next_word} !== 4'b0111) begin n_fail++; $display("FAIL ea_s4 got %b expected 0111", {eop, init_cur, next_word}); end
        bus.end_of_process_in = 1'b1; encoded_dma = 4'b0000; bus.hold_acknowledge = 1'b0;
        @(negedge clock);
        n_checks++; if ({bus.hold_request, init_cur, eop} !== 4'b0010) begin n_fail++; $display("FAIL ea_end got %b expected 0010", {bus.hold_request, init_cur, eop}); end
        n_checks++; if (cnt !== 16'd4) begin n_fail++; $display("FAIL ea_count got %h expected 0004", cnt); end
    endtask

    task automatic test_master_clear;
        setup(8'h84, 16'd5);
        encoded_dma = 4'b0001;
        @(negedge clock);
        bus.hold_acknowledge = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (strobes !== 4'b1001) begin n_fail++; $display("FAIL mc_s3 got %b expected 1001", strobes); end
        mclr = 1'b1; encoded_dma = 4'b0000; bus.hold_acknowledge = 1'b0;
        @(negedge clock);
        mclr = 1'b0;
        n_checks++; if ({ctl, strobes, dack, next_word} !== 13'b0000_1111_0000_0) begin n_fail++; $display("FAIL mc_after got %b expected 0000111100000", {ctl, strobes, dack, next_word}); end
        // Cleared mode register means a demand verify transfer: no strobes at all
        encoded_dma = 4'b0001;
        @(negedge clock);
        bus.hold_acknowledge = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (strobes !== 4'b1111) begin n_fail++; $display("FAIL mc_verify_s2 got %b expected 1111", strobes); end
        encoded_dma = 4'b0000;
        @(negedge clock);
        n_checks++; if (strobes !== 4'b1111) begin n_fail++; $display("FAIL mc_verify_s3 got %b expected 1111", strobes); end
        @(negedge clock);
        bus.hold_acknowledge = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.hold_request !== 1'b0) begin n_fail++; $display("FAIL mc_verify_end got %b expected 0", bus.hold_request); end
        n_checks++; if (cnt !== 16'd4) begin n_fail++; $display("FAIL mc_count got %h expected 0004", cnt); end
    endtask

    task automatic test_async_reset;
        setup(8'h49, 16'd5);
        encoded_dma = 4'b0010;
        @(negedge clock);
        bus.hold_acknowledge = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (strobes !== 4'b0111) begin n_fail++; $display("FAIL ar_s2 got %b expected 0111", strobes); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if ({ctl, strobes, dack, select, eop} !== 18'b0000_1111_0000_0000_10) begin n_fail++; $display("FAIL ar_async got %b expected 000011110000000010", {ctl, strobes, dack, select, eop}); end
        encoded_dma = 4'b0000; bus.hold_acknowledge = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++; if (bus.hold_request !== 1'b0) begin n_fail++; $display("FAIL ar_release got %b expected 0", bus.hold_request); end
    endtask

    initial begin
        reset_n = 1'b0;
        data = 8'h00; wr_mode = 1'b0; wr_cmd = 1'b0; mclr = 1'b0; encoded_dma = 4'b0000;
        cnt_load = 1'b1; cnt_load_val = 16'd0;
        bus.hold_acknowledge = 1'b0; bus.ready = 1'b1; bus.end_of_process_in = 1'b1;
        test_reset();
        test_disable_and_withdraw();
        test_single_read();
        test_block_write();
        test_demand();
        test_ready_wait();
        test_eop_autoinit();
        test_master_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kf8237_timing_and_control.md
Name: kf8237_timing_and_control

Overview:
- Transfer sequencer of the KF8237 DMA controller.
- Owns the per-channel mode registers and runs the bus-cycle state machine: hold handshake, address enable/strobe, DACK, memory/IO strobes, READY wait states and EOP/terminal count.
- Drives the address/count register block (select, next_word, autoinit reload) and feeds DACK/EOP back to the priority encoder.
- Sits beside the bus control logic, priority encoder and address/count registers inside the KF8237 top.

Parameters:
- CHANNELS, 4, number of DMA channels (sets one-hot vector widths).

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
internal_data_bus  in  8  CPU write data from bus control logic
write_mode_register  in  1  one-cycle pulse: load mode register of channel internal_data_bus[1:0]
write_command_register  in  1  one-cycle pulse: bit2 of internal_data_bus = controller disable
master_clear  in  1  software reset pulse
encoded_dma  in  4  one-hot granted request from priority encoder, 0 = none
hold_acknowledge  in  1  HLDA from CPU
ready  in  1  high = complete cycle, low = insert wait state
end_of_process_in  in  1  external EOP, active low
underflow  in  1  selected channel's current word count is 0 (last transfer)
hold_request  out  1  HRQ
dma_acknowledge_internal  out  4  one-hot DACK, active high
end_of_process_internal  out  1  TC/EOP pulse to priority encoder
end_of_process_out  out  1  EOP pin, active low
transfer_register_select  out  4  one-hot channel selected in address/count block
next_word  out  1  one-cycle pulse: increment/decrement address, decrement count
initialize_current_register  out  1  one-cycle pulse: autoinit reload current from base
decrement_address_config  out  1  mode bit5 of active channel
address_enable  out  1  AEN
address_strobe  out  1  ADSTB
memory_read_n  out  1  MEMR#
memory_write_n  out  1  MEMW#
io_read_n_out  out  1  IOR# (drive)
io_write_n_out  out  1  IOW# (drive)
lock_bus_control  out  1  high from S1 through S4: bus control ignores CPU I/O

Behaviour:
- Reset or master_clear: state SI, mode registers 0, disable 0. HRQ, DACK, AEN, ADSTB, pulse outputs and select = 0. All *_n outputs and end_of_process_out = 1. master_clear is synchronous and aborts any cycle immediately.
- Mode register layout (8 bits/channel):
  - [3:2] type: 00 verify, 01 write (IOR#+MEMW#), 10 read (MEMR#+IOW#), 11 treated as verify.
  - [4] autoinit.
  - [5] decrement.
  - [7:6] mode: 00 demand, 01 single, 10 block, 11 cascade.
- SI: if encoded_dma != 0 and not disabled, go to S0 next cycle with HRQ=1.
- S0: HRQ=1. When hold_acknowledge=1 and encoded_dma != 0, latch channel = encoded_dma and go to S1. If encoded_dma drops to 0 before HLDA, return to SI and drop HRQ.
- S1: AEN=1, ADSTB=1, select=channel, DACK=channel, lock=1. Next state S2.
- S2: ADSTB=0, read strobe low (MEMR# for read, IOR# for write, none for verify). Next state S3.
- S3: write strobe low (IOW# for read, MEMW# for write). If ready=0, stay in S3 holding all strobes (wait state). If ready=1, go to S4.
- S4: all strobes high; next_word=1 for exactly one cycle. TC = underflow | !end_of_process_in sampled in S4.
  - On TC: end_of_process_out=0 and end_of_process_internal=1 for this cycle; initialize_current_register=1 if autoinit.
- After S4, decision order:
  - TC → SI.
  - single → SI, dropping HRQ/AEN/DACK for at least one cycle.
  - block → S1.
  - demand → S1 if encoded_dma still equals channel, else SI.
- Cascade: after HLDA, DACK=channel, HRQ stays high while encoded_dma == channel. No AEN, no strobes, no next_word. Return to SI when the request drops.
- Disable bit set mid-transfer: finish the current cycle through S4, then SI.
- HRQ asserts 1 cycle after request; first strobe is 2 cycles after HLDA; minimum 4 cycles per transfer.
- decrement_address_config is valid whenever select != 0.

Decomposition:
- Package kf8237_pkg holds:
  - state enum (SI, S0, S1, S2, S3, S4);
  - transfer type enum and mode enum;
  - mode-register bit-field constants.
- Sub-module kf8237_mode_registers: 4×8 storage, write decode, active-channel field mux.
- The FSM stays in this module.

Test Plan:
- Ch1 single read, mode 0x49, HLDA 1 cycle after HRQ, count 2 → three transfers, HRQ drops between each. MEMR# low S2–S3, IOW# low S3, EOP low on the 3rd S4.
- Ch0 block write, mode 0x84 → back-to-back S1–S4 with IOR#+MEMW#, next_word 4 pulses for count 3, then SI.
- Ch2 demand, DREQ removed after 2 transfers → return to SI without TC or EOP, current address preserved.
- ready=0 for 3 cycles in S3 → strobes held 4 cycles, then one next_word.
- External EOP low during S4 of transfer 1, mode 0x58 (autoinit) → TC, initialize_current_register pulse, return to SI.
- master_clear during S3 → all strobes high and HRQ 0 next cycle. Then asynchronous reset_n low mid-S2 → immediate reset values.
